// File: rtl/relu_sparse_queue.sv
// Double-buffered ReLU activation queue: captures a packed vector in one cycle
// and streams its nonzero (or all) elements out as (index, value) pairs.
module relu_sparse_queue #(
  parameter int unsigned NODES       = 3,
  parameter int unsigned VALUE_WIDTH = 4,
  parameter int unsigned INDEX_WIDTH = (NODES > 1) ? $clog2(NODES) : 1,
  parameter bit          SKIP_ZEROS  = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NODES*VALUE_WIDTH-1:0] node_values,
  input  logic                         write_enable,
  output logic                         load_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [INDEX_WIDTH-1:0]       index_out,
  output logic [VALUE_WIDTH-1:0]       value_out,
  output logic                         last_out,
  output logic                         queue_empty,
  output logic [INDEX_WIDTH:0]         pending_count,
  output logic                         overflow
);

  localparam int unsigned CNT_WIDTH = INDEX_WIDTH + 1;

  logic [VALUE_WIDTH-1:0] a_val_q [NODES];
  logic [VALUE_WIDTH-1:0] a_val_d [NODES];
  logic [VALUE_WIDTH-1:0] s_val_q [NODES];
  logic [VALUE_WIDTH-1:0] s_val_d [NODES];
  logic [VALUE_WIDTH-1:0] load_val [NODES];
  logic [NODES-1:0]       a_mask_q, a_mask_d, s_mask_q, s_mask_d;
  logic [NODES-1:0]       load_mask, sel_oh, a_mask_pop;
  logic                   overflow_q, overflow_d;
  logic                   a_full, s_full, pop, accept;
  logic [INDEX_WIDTH-1:0] sel_idx;
  logic [VALUE_WIDTH-1:0] sel_val;
  logic [CNT_WIDTH-1:0]   cnt;

  // Unpack the load vector (node 0 in the MSBs) and build its pending mask.
  always_comb begin
    for (int i = 0; i < NODES; i++) begin
      load_val[i]  = node_values[(NODES-i)*VALUE_WIDTH-1 -: VALUE_WIDTH];
      load_mask[i] = SKIP_ZEROS ? (load_val[i] != '0) : 1'b1;
    end
  end

  // Fixed-priority selection of the lowest pending node in the active bank.
  always_comb begin
    sel_idx = '0;
    sel_val = '0;
    cnt     = '0;
    for (int i = NODES - 1; i >= 0; i--) begin
      if (a_mask_q[i]) begin
        sel_idx = INDEX_WIDTH'(i);
        sel_val = a_val_q[i];
      end
    end
    for (int i = 0; i < NODES; i++) begin
      cnt = cnt + CNT_WIDTH'(a_mask_q[i]);
    end
  end

  assign sel_oh = a_mask_q & (~a_mask_q + NODES'(1));
  assign a_full = |a_mask_q;
  assign s_full = |s_mask_q;

  assign load_ready    = !s_full;
  assign out_valid     = a_full;
  assign queue_empty   = !a_full;
  assign pending_count = cnt;
  assign index_out     = a_full ? sel_idx : '0;
  assign value_out     = a_full ? sel_val : '0;
  assign last_out      = a_full && (cnt == CNT_WIDTH'(1));
  assign overflow      = overflow_q;

  assign pop        = a_full && out_ready;
  assign accept     = write_enable && load_ready;
  assign a_mask_pop = pop ? (a_mask_q & ~sel_oh) : a_mask_q;

  // Bank update: pop, shadow-to-active swap, then load placement.
  always_comb begin
    a_mask_d   = a_mask_pop;
    s_mask_d   = s_mask_q;
    a_val_d    = a_val_q;
    s_val_d    = s_val_q;
    overflow_d = overflow_q;
    if ((a_mask_pop == '0) && s_full) begin
      a_mask_d = s_mask_q;
      a_val_d  = s_val_q;
      s_mask_d = '0;
      for (int i = 0; i < NODES; i++) s_val_d[i] = '0;
    end
    if (accept && (load_mask != '0)) begin
      if (a_mask_pop == '0) begin
        a_mask_d = load_mask;
        a_val_d  = load_val;
      end else begin
        s_mask_d = load_mask;
        s_val_d  = load_val;
      end
    end
    if (write_enable && !load_ready) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_mask_q   <= '0;
      s_mask_q   <= '0;
      overflow_q <= 1'b0;
      for (int i = 0; i < NODES; i++) begin
        a_val_q[i] <= '0;
        s_val_q[i] <= '0;
      end
    end else begin
      a_mask_q   <= a_mask_d;
      s_mask_q   <= s_mask_d;
      overflow_q <= overflow_d;
      a_val_q    <= a_val_d;
      s_val_q    <= s_val_d;
    end
  end

endmodule

// File: tb/tb_relu_sparse_queue.sv
// Scoreboard bench for relu_sparse_queue (3 nodes x 4 bits), plus a
// SKIP_ZEROS=0 instance for the emit-all mode.
module tb_relu_sparse_queue;

  localparam int unsigned N  = 3;
  localparam int unsigned VW = 4;
  localparam int unsigned IW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [N*VW-1:0] node_values;
  logic          write_enable, out_ready;
  logic          load_ready, out_valid, last_out, queue_empty, overflow;
  logic [IW-1:0] index_out;
  logic [VW-1:0] value_out;
  logic [IW:0]   pending_count;

  logic          we_z, rdy_z;
  logic          load_ready_z, valid_z, last_z, empty_z, overflow_z;
  logic [IW-1:0] index_z;
  logic [VW-1:0] value_z;
  logic [IW:0]   count_z;

  int n_checks = 0;
  int n_fail   = 0;
  logic [IW+VW:0] sb [$];

  always #5 clk = ~clk;

  relu_sparse_queue #(.NODES(N), .VALUE_WIDTH(VW), .SKIP_ZEROS(1'b1)) dut (
    .clk(clk), .reset(reset), .node_values(node_values),
    .write_enable(write_enable), .load_ready(load_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .index_out(index_out), .value_out(value_out), .last_out(last_out),
    .queue_empty(queue_empty), .pending_count(pending_count),
    .overflow(overflow)
  );

  relu_sparse_queue #(.NODES(N), .VALUE_WIDTH(VW), .SKIP_ZEROS(1'b0)) dut_all (
    .clk(clk), .reset(reset), .node_values(node_values),
    .write_enable(we_z), .load_ready(load_ready_z),
    .out_valid(valid_z), .out_ready(rdy_z),
    .index_out(index_z), .value_out(value_z), .last_out(last_z),
    .queue_empty(empty_z), .pending_count(count_z),
    .overflow(overflow_z)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected stream of a vector under SKIP_ZEROS=1.
  task automatic push_expected(input logic [N*VW-1:0] vec);
    logic [VW-1:0] v;
    int last_i;
    last_i = -1;
    for (int i = 0; i < N; i++) begin
      v = vec[(N-i)*VW-1 -: VW];
      if (v != 0) last_i = i;
    end
    for (int i = 0; i < N; i++) begin
      v = vec[(N-i)*VW-1 -: VW];
      if (v != 0) sb.push_back({IW'(i), v, (i == last_i)});
    end
  endtask

  task automatic do_load(input logic [N*VW-1:0] vec, input logic exp_acc);
    check("load_ready", 32'(load_ready), 32'(exp_acc));
    node_values  = vec;
    write_enable = 1'b1;
    if (exp_acc) push_expected(vec);
    tick();
    write_enable = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0 && queue_empty) break;
      @(negedge clk);
    end
    check("drain", 32'(sb.size() == 0 && queue_empty), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_index"}, 32'(index_out), 32'd0);
    check({tag, "_value"}, 32'(value_out), 32'd0);
    check({tag, "_last"}, 32'(last_out), 32'd0);
    check({tag, "_empty"}, 32'(queue_empty), 32'd1);
    check({tag, "_load_ready"}, 32'(load_ready), 32'd1);
    check({tag, "_count"}, 32'(pending_count), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
  endtask

  // Every accepted element is compared against the scoreboard head.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) check("elem", 32'({index_out, value_out, last_out}), 32'(sb.pop_front()));
    end
  end

  initial begin
    reset = 1'b0; node_values = '0; write_enable = 1'b0; out_ready = 1'b0;
    we_z = 1'b0; rdy_z = 1'b0;
    #12;
    check_reset_outputs("rst");
    #1 reset = 1'b1;
    tick();

    // Basic stream with one-cycle latency and last on the final element.
    out_ready = 1'b1;
    do_load(12'h673, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("basic_valid", 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    check("basic_done_valid", 32'(out_valid), 32'd0);
    check("basic_done_empty", 32'(queue_empty), 32'd1);
    wait_drain();
    tick();

    // Sparse vector and all-zero vector.
    do_load(12'h050, 1'b1);
    wait_drain();
    tick();
    do_load(12'h000, 1'b1);
    @(negedge clk);
    check("zero_valid", 32'(out_valid), 32'd0);
    check("zero_overflow", 32'(overflow), 32'd0);
    check("zero_load_ready", 32'(load_ready), 32'd1);
    tick();

    // Emit-all mode on the second instance.
    rdy_z = 1'b1;
    node_values = 12'h050;
    we_z = 1'b1;
    tick();
    we_z = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("all_elem", 32'({valid_z, index_z, value_z, last_z}),
            32'({1'b1, IW'(i), (i == 1) ? 4'd5 : 4'd0, (i == 2)}));
    end
    @(negedge clk);
    check("all_done", 32'(valid_z), 32'd0);
    tick();

    // Both banks full, third load dropped and flagged.
    out_ready = 1'b0;
    do_load(12'h673, 1'b1);
    do_load(12'h124, 1'b1);
    check("full_load_ready", 32'(load_ready), 32'd0);
    check("full_count", 32'(pending_count), 32'd3);
    do_load(12'h999, 1'b0);
    check("full_overflow", 32'(overflow), 32'd1);
    check("full_count_after", 32'(pending_count), 32'd3);
    out_ready = 1'b1;
    wait_drain();
    check("overflow_sticky", 32'(overflow), 32'd1);
    tick();

    // Back-to-back vectors with no bubble at the swap.
    do_load(12'h673, 1'b1);
    do_load(12'h124, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("b2b_valid", 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    check("b2b_done", 32'(out_valid), 32'd0);
    wait_drain();
    tick();

    // Backpressure while presenting (1,7).
    do_load(12'h673, 1'b1);
    tick();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold", 32'({out_valid, index_out, value_out, last_out}),
            32'({1'b1, 2'd1, 4'd7, 1'b0}));
      check("bp_count", 32'(pending_count), 32'd2);
      tick();
    end
    out_ready = 1'b1;
    wait_drain();
    tick();

    // Asynchronous reset mid-drain, then a fresh sparse load.
    do_load(12'h673, 1'b1);
    tick();
    #2 reset = 1'b0;
    sb.delete();
    #1;
    check_reset_outputs("arst");
    #2 reset = 1'b1;
    tick();
    do_load(12'h209, 1'b1);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1);
  end

endmodule
